edge_event_monitor: RTL
=======================

// Module: edge_event_monitor
// PURPOSE
//   Parametrised, synthesizable multi-channel event detector. Watches N_CH async
//   inputs and detects rising, falling or any edges per channel, selected by mode.
//   Provides one-cycle event pulses, sticky write-1-clear flags, saturating
//   per-channel counters and a masked interrupt. Sits between raw external
//   signals and status/interrupt logic.
// PARAMETERS
//   N_CH        4  number of monitored channels (>=1)
//   CNT_W       8  width of each per-channel event counter
//   SYNC_STAGES 2  synchronizer flops per input (>=2)
//   CH_W        localparam = (N_CH>1) ? $clog2(N_CH) : 1
// PORTS
//   clk        in   1           clock; all state on posedge
//   rst        in   1           synchronous active-high reset
//   sig_in     in   N_CH        async inputs, one bit per channel
//   mode       in   2*N_CH      per ch {mode[2i+1],mode[2i]}: 00 off, 01 rise, 10 fall, 11 any
//   clr_flag   in   N_CH        write-1-clear for evt_flag, per channel
//   cnt_clr    in   1           clear all counters
//   irq_en     in   N_CH        interrupt mask per channel
//   evt_pulse  out  N_CH        1-cycle pulse per detected event
//   evt_flag   out  N_CH        sticky event flags
//   evt_cnt    out  N_CH*CNT_W  counters, ch i at [i*CNT_W +: CNT_W]
//   evt_any    out  1           OR of evt_pulse
//   last_ch    out  CH_W        lowest-index channel of most recent evt_any cycle
//   irq        out  1           |(evt_flag & irq_en), combinational from regs
// BEHAVIOUR
//   - Reset: sync chains, prev, evt_pulse, evt_flag, evt_cnt, last_ch, and the
//     settle counter all go to 0; evt_any=0 and irq=0 follow.
//   - Settle: detection is suppressed until SYNC_STAGES+1 edges after rst
//     deasserts, so levels held at reset release never produce events.
//   - Pipeline: sig_in -> SYNC_STAGES flops -> s; prev <= s every cycle regardless
//     of mode. rise = s&~prev, fall = ~s&prev.
//   - Latency: evt_pulse is registered. A change on sig_in before edge 0 gives
//     evt_pulse high after edge SYNC_STAGES, for exactly 1 cycle.
//   - Mode: 00 gives no pulse, flag or count. A mode change applies at the next
//     comparison. prev keeps tracking, so a mode change never creates an event.
//   - Flags and counters update on the same edge as evt_pulse is set.
//   - Flag priority: set beats clear. If clr_flag[i] and a new event on ch i occur
//     in the same cycle, flag[i] stays 1.
//   - Counter: +1 per event, saturates at 2^CNT_W-1 with no wrap. If cnt_clr and
//     an event occur together, count loads 1; cnt_clr alone loads 0.
//   - last_ch: updated only in cycles where an event is detected, with the lowest
//     firing index; held otherwise.
//   - Reset mid-operation: everything returns to reset state in 1 edge, in-flight
//     sync data is discarded, and the settle window reapplies.
// TESTING (N_CH=4, SYNC_STAGES=2, CNT_W=8 unless noted)
//   1 sig_in=4'hF through reset, release, hold -> no evt_pulse, flags, counts or irq ever.
//   2 ch0 mode=01, sig_in[0] 0->1 before edge 10 -> evt_pulse[0]=1 only after edge 12, flag0=1, cnt0=1; 1->0 -> nothing.
//   3 ch1 mode=11 toggled 3x; ch2 mode=10 rise only -> cnt1=3 with 3 pulses; cnt2=0, flag2=0.
//   4 ch1 and ch3 rise same cycle; clr_flag[1] on that pulse edge -> evt_any=1, last_ch=1, flag1 stays 1; irq_en=4'b1000 -> irq=1.
//   5 CNT_W=4, 20 events on ch0 -> cnt0=15. Then cnt_clr with event -> 1; cnt_clr alone -> 0.
//   6 rst for 1 cycle mid-stream with events pending in sync -> all outputs 0, no pulse during settle window.

Source files
------------

// File: rtl/edge_event_monitor_if.sv
// Bundle of the edge monitor's control inputs and status outputs.
// The slave modport is the monitor itself; master is whoever drives it.
interface edge_event_monitor_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]       sig_in;
    logic [2*N_CH-1:0]     mode;
    logic [N_CH-1:0]       clr_flag;
    logic                  cnt_clr;
    logic [N_CH-1:0]       irq_en;
    logic [N_CH-1:0]       evt_pulse;
    logic [N_CH-1:0]       evt_flag;
    logic [N_CH*CNT_W-1:0] evt_cnt;
    logic                  evt_any;
    logic [CH_W-1:0]       last_ch;
    logic                  irq;

    modport master (
        output sig_in, mode, clr_flag, cnt_clr, irq_en,
        input  evt_pulse, evt_flag, evt_cnt, evt_any, last_ch, irq
    );

    modport slave (
        input  sig_in, mode, clr_flag, cnt_clr, irq_en,
        output evt_pulse, evt_flag, evt_cnt, evt_any, last_ch, irq
    );
endinterface

// File: rtl/edge_event_monitor.sv
// Multi-channel edge detector: synchronises async inputs, detects per-channel
// rise/fall/any edges and keeps pulses, sticky flags, saturating counts and an irq.
module edge_event_monitor #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    edge_event_monitor_if.slave  bus
);
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SETTLE_MAX = SYNC_STAGES + 1;
    localparam int SET_W      = $clog2(SETTLE_MAX + 1);

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  prev_q;
    logic [N_CH-1:0]  pulse_q;
    logic [N_CH-1:0]  flag_vec;
    logic [N_CH-1:0]  s;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  fall;
    logic [N_CH-1:0]  det;
    logic [CH_W-1:0]  last_ch_q;
    logic [CH_W-1:0]  last_ch_d;
    logic [SET_W-1:0] settle_q;
    logic             settled;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~prev_q;
    assign fall    = ~s & prev_q;
    assign settled = (settle_q == SET_W'(SETTLE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q   <= '0;
            settle_q <= '0;
        end else begin
            sync_q[0] <= bus.sig_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= s;
            // Hold off detection until the chain and prev reflect post-reset levels.
            if (!settled) begin
                settle_q <= settle_q + SET_W'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic             flag_q;
            logic [CNT_W-1:0] cnt_q;

            assign det[gi] = settled &
                             ((bus.mode[2*gi]   & rise[gi]) |
                              (bus.mode[2*gi+1] & fall[gi]));

            always_ff @(posedge clk) begin
                if (rst) begin
                    flag_q <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    // A new event wins over a same-cycle write-1-clear.
                    if (det[gi]) begin
                        flag_q <= 1'b1;
                    end else if (bus.clr_flag[gi]) begin
                        flag_q <= 1'b0;
                    end

                    if (det[gi]) begin
                        if (bus.cnt_clr) begin
                            cnt_q <= CNT_W'(1);
                        end else if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (bus.cnt_clr) begin
                        cnt_q <= '0;
                    end
                end
            end

            assign flag_vec[gi]                  = flag_q;
            assign bus.evt_cnt[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

    always_comb begin
        last_ch_d = last_ch_q;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (det[i]) begin
                last_ch_d = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q   <= '0;
            last_ch_q <= '0;
        end else begin
            pulse_q   <= det;
            last_ch_q <= last_ch_d;
        end
    end

    assign bus.evt_pulse = pulse_q;
    assign bus.evt_flag  = flag_vec;
    assign bus.evt_any   = |pulse_q;
    assign bus.last_ch   = last_ch_q;
    assign bus.irq       = |(flag_vec & bus.irq_en);
endmodule
